shift_deserializer: RTL and testbench

- Serial-to-parallel receiver; the opposite end of the shifter-with-parallel-load transmitter.
- Collects BUSWIDTH serial bits, MSB-first or LSB-first, matching the shift-left/shift-right modes.
- Presents each completed word on a registered parallel output with a valid/ready handshake.
- One-word output buffer, so a new frame can shift in while the previous word waits.

---
 rtl/shift_deserializer.sv | 132 +++++++++++++
 tb/tb_shift_deserializer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver with a one-word valid/ready output buffer.
// Define DESER_PARITY_CHECK_EN to expect an even-parity bit after each word.
module shift_deserializer #(
    parameter int BUSWIDTH = 8
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                start_i,
    input  logic                dir_i,
    input  logic                serial_i,
    input  logic                serial_valid_i,
    input  logic                ready_i,
    output logic [BUSWIDTH-1:0] data_o,
    output logic                valid_o,
    output logic                busy_o,
    output logic                overrun_o,
    output logic                parity_err_o
);

    localparam int CNT_W = $clog2(BUSWIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BUSWIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t              state;
    logic [BUSWIDTH-1:0] sreg;
    logic [BUSWIDTH-1:0] sreg_shifted;
    logic [CNT_W-1:0]    count;
    logic                dir_r;
    logic                word_done;
    logic [BUSWIDTH-1:0] word;

    always_comb begin
        sreg_shifted = dir_r ? {serial_i, sreg[BUSWIDTH-1:1]}
                             : {sreg[BUSWIDTH-2:0], serial_i};
    end

`ifdef DESER_PARITY_CHECK_EN
    // The word is already complete in sreg; the parity bit only finishes the frame.
    logic parity_q;
    logic word_perr;

    assign word_done    = (state == PARITY) && serial_valid_i && !start_i;
    assign word         = sreg;
    assign word_perr    = ^{sreg, serial_i};
    assign parity_err_o = parity_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            parity_q <= 1'b0;
        end else if (word_done && (!valid_o || ready_i)) begin
            parity_q <= word_perr;
        end
    end
`else
    assign word_done    = (state == SHIFT) && serial_valid_i && !start_i && (count == LAST_BIT);
    assign word         = sreg_shifted;
    assign parity_err_o = 1'b0;
`endif

    assign busy_o = (state != IDLE);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            sreg      <= '0;
            count     <= '0;
            dir_r     <= 1'b0;
            data_o    <= '0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            overrun_o <= 1'b0;

            // A draining buffer can take the new word on the same edge.
            if (word_done) begin
                if (!valid_o || ready_i) begin
                    data_o  <= word;
                    valid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start_i) begin
                        state <= SHIFT;
                        count <= '0;
                        dir_r <= dir_i;
                    end
                end
                SHIFT: begin
                    if (start_i) begin
                        count <= '0;
                        dir_r <= dir_i;
                    end else if (serial_valid_i) begin
                        sreg <= sreg_shifted;
                        if (count == LAST_BIT) begin
`ifdef DESER_PARITY_CHECK_EN
                            state <= PARITY;
`else
                            state <= IDLE;
`endif
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
`ifdef DESER_PARITY_CHECK_EN
                PARITY: begin
                    if (start_i) begin
                        state <= SHIFT;
                        count <= '0;
                        dir_r <= dir_i;
                    end else if (serial_valid_i) begin
                        state <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_deserializer.sv
// Scoreboard bench for shift_deserializer; the monitor checks every word as it is consumed.
// Define DESER_PARITY_CHECK_EN here and in the RTL to exercise the parity frame.
module tb_shift_deserializer;

`ifdef DESER_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       Clk;
    logic       Rst_n;
    logic       start_i;
    logic       dir_i;
    logic       serial_i;
    logic       serial_valid_i;
    logic       ready_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       busy_o;
    logic       overrun_o;
    logic       parity_err_o;

    int         tests_run;
    int         tests_failed;
    int         overrun_count;
    logic [8:0] exp_q[$];

    shift_deserializer #(.BUSWIDTH(8)) dut (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .start_i        (start_i),
        .dir_i          (dir_i),
        .serial_i       (serial_i),
        .serial_valid_i (serial_valid_i),
        .ready_i        (ready_i),
        .data_o         (data_o),
        .valid_o        (valid_o),
        .busy_o         (busy_o),
        .overrun_o      (overrun_o),
        .parity_err_o   (parity_err_o)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Monitor: a word is consumed at the next rising edge when valid and ready are both high.
    always @(negedge Clk) begin
        if (Rst_n) begin
            if (overrun_o) overrun_count++;
            if (valid_o && ready_i) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL scoreboard: unexpected word data=%h perr=%b, expected none",
                             data_o, parity_err_o);
                end else begin
                    logic [8:0] exp_w;
                    exp_w = exp_q.pop_front();
                    if ({parity_err_o, data_o} !== exp_w) begin
                        tests_failed++;
                        $display("[TB] FAIL scoreboard: got data=%h perr=%b, expected data=%h perr=%b",
                                 data_o, parity_err_o, exp_w[7:0], exp_w[8]);
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic d, input logic sv, input logic b);
        start_i        = st;
        dir_i          = d;
        serial_valid_i = sv;
        serial_i       = b;
        @(posedge Clk);
        #1;
        start_i        = 1'b0;
        serial_valid_i = 1'b0;
    endtask

    // seq[7] is transmitted first.
    task automatic sendFrame(input logic dir, input logic [7:0] seq, input bit gaps,
                             input logic par, input bit chk_mid, input bit ready_last);
        applyStimulus(1'b1, dir, 1'b0, 1'b0);
        for (int i = 7; i >= 0; i--) begin
            if (ready_last && i == 0 && !PAR_EN) ready_i = 1'b1;
            applyStimulus(1'b0, dir, 1'b1, seq[i]);
            if (chk_mid && (i > 0 || PAR_EN)) checkOutput("mid_frame_valid", {31'd0, valid_o}, 32'd0);
            if (gaps && (i == 6 || i == 3)) begin
                for (int g = 0; g < 3; g++) applyStimulus(1'b0, dir, 1'b0, 1'b0);
            end
        end
`ifdef DESER_PARITY_CHECK_EN
        if (ready_last) ready_i = 1'b1;
        applyStimulus(1'b0, dir, 1'b1, par);
`else
        serial_i = par;
`endif
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        overrun_count  = 0;
        Rst_n          = 1'b0;
        start_i        = 1'b0;
        dir_i          = 1'b0;
        serial_i       = 1'b0;
        serial_valid_i = 1'b0;
        ready_i        = 1'b0;

        repeat (2) @(posedge Clk);
        #1;
        checkOutput("reset_valid", {31'd0, valid_o}, 32'd0);
        checkOutput("reset_data", {24'd0, data_o}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("reset_overrun", {31'd0, overrun_o}, 32'd0);
        checkOutput("reset_perr", {31'd0, parity_err_o}, 32'd0);
        Rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // MSB-first 0xA5, back-to-back bits, held in the buffer until ready rises.
        exp_q.push_back({1'b0, 8'hA5});
        sendFrame(1'b0, 8'b10100101, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t1_valid_latency", {31'd0, valid_o}, 32'd1);
        checkOutput("t1_data", {24'd0, data_o}, 32'hA5);
        checkOutput("t1_busy_done", {31'd0, busy_o}, 32'd0);
        ready_i = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t1_consumed", {31'd0, valid_o}, 32'd0);

        // Same word with serial_valid gaps after the 2nd and 5th bits.
        exp_q.push_back({1'b0, 8'hA5});
        sendFrame(1'b0, 8'b10100101, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("t2_valid", {31'd0, valid_o}, 32'd1);
        checkOutput("t2_data", {24'd0, data_o}, 32'hA5);

        // LSB-first 0x3C, then an aborted 3-bit frame restarted into 0x5A.
        exp_q.push_back({1'b0, 8'h3C});
        sendFrame(1'b1, 8'b00111100, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t3_data_first", {24'd0, data_o}, 32'h3C);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("t3_busy_partial", {31'd0, busy_o}, 32'd1);
        exp_q.push_back({1'b0, 8'h5A});
        sendFrame(1'b1, 8'b01011010, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t3_data_second", {24'd0, data_o}, 32'h5A);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t3_no_overrun", overrun_count, 32'd0);

        // Buffer full and stalled: the second word is dropped with an overrun pulse.
        ready_i = 1'b0;
        exp_q.push_back({1'b0, 8'h11});
        sendFrame(1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        sendFrame(1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t4_overrun_pulse", {31'd0, overrun_o}, 32'd1);
        checkOutput("t4_data_kept", {24'd0, data_o}, 32'h11);
        checkOutput("t4_valid_kept", {31'd0, valid_o}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t4_overrun_one_cycle", {31'd0, overrun_o}, 32'd0);
        checkOutput("t4_overrun_count", overrun_count, 32'd1);
        ready_i = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t4_drained", {31'd0, valid_o}, 32'd0);

        // Drain and reload on the same edge.
        ready_i = 1'b0;
        exp_q.push_back({1'b0, 8'h33});
        sendFrame(1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_q.push_back({1'b0, 8'h44});
        sendFrame(1'b0, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t4_reload_valid", {31'd0, valid_o}, 32'd1);
        checkOutput("t4_reload_data", {24'd0, data_o}, 32'h44);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t4_reload_consumed", {31'd0, valid_o}, 32'd0);
        checkOutput("t4_overrun_total", overrun_count, 32'd1);

        // Asynchronous reset mid-frame discards both the buffered word and the partial frame.
        ready_i = 1'b0;
        sendFrame(1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t5_buffered", {31'd0, valid_o}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        Rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_valid", {31'd0, valid_o}, 32'd0);
        checkOutput("t5_rst_data", {24'd0, data_o}, 32'd0);
        checkOutput("t5_rst_busy", {31'd0, busy_o}, 32'd0);
        @(posedge Clk);
        #1;
        Rst_n   = 1'b1;
        ready_i = 1'b1;
        exp_q.push_back({1'b0, 8'hFF});
        sendFrame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t5_data_ff", {24'd0, data_o}, 32'hFF);

        // Wrong parity bit on 0xA5 raises parity_err_o when the check is built in.
        exp_q.push_back({PAR_EN, 8'hA5});
        sendFrame(1'b0, 8'b10100101, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("t6_valid", {31'd0, valid_o}, 32'd1);
        checkOutput("t6_perr", {31'd0, parity_err_o}, {31'd0, PAR_EN});
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
